// File: rtl/alu_issue_ctrl.sv
// Issue controller for a combinational ALU: owns the register file, sequences
// operand read, execute, result capture and writeback, and reports completion.
module alu_issue_ctrl #(
  parameter int WIDTH = 19,
  parameter int NREGS = 8,
  parameter int IDX_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [IDX_W-1:0] req_rd,
  input  logic [IDX_W-1:0] req_rs1,
  input  logic [IDX_W-1:0] req_rs2,
  input  logic             ld_en,
  input  logic [IDX_W-1:0] ld_idx,
  input  logic [WIDTH-1:0] ld_data,
  input  logic [IDX_W-1:0] dbg_idx,
  output logic [WIDTH-1:0] dbg_data,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  output logic             done,
  output logic             zero_flag,
  output logic             div0_err
);

  localparam logic [2:0] OP_DIV = 3'b011;

  typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

  state_t           state_reg;
  logic [2:0]       op_reg;
  logic [IDX_W-1:0] rd_reg;
  logic [IDX_W-1:0] rs1_reg;
  logic [IDX_W-1:0] rs2_reg;
  logic [WIDTH-1:0] res_reg;
  logic             zero_reg;
  logic             div0_reg;

  logic [WIDTH-1:0] rf [NREGS];

  logic             wr_en_next;
  logic [IDX_W-1:0] wr_idx_next;
  logic [WIDTH-1:0] wr_data_next;

  assign req_ready = (state_reg == IDLE) && !ld_en;
  assign dbg_data  = rf[dbg_idx];

  // Loads and writebacks share one write port; they can never collide since
  // loads are only honoured in IDLE and writeback only happens in WB.
  always_comb begin
    wr_en_next   = 1'b0;
    wr_idx_next  = ld_idx;
    wr_data_next = ld_data;
    if (state_reg == IDLE && ld_en) begin
      wr_en_next = 1'b1;
    end else if (state_reg == WB) begin
      wr_en_next   = 1'b1;
      wr_idx_next  = rd_reg;
      wr_data_next = res_reg;
    end
  end

  // r0 has no storage, so any write addressed to it simply falls away.
  assign rf[0] = '0;

  generate
    for (genvar gi = 1; gi < NREGS; gi++) begin : g_reg
      logic [WIDTH-1:0] q_reg;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          q_reg <= '0;
        end else if (wr_en_next && wr_idx_next == IDX_W'(gi)) begin
          q_reg <= wr_data_next;
        end
      end

      assign rf[gi] = q_reg;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      op_reg    <= '0;
      rd_reg    <= '0;
      rs1_reg   <= '0;
      rs2_reg   <= '0;
      res_reg   <= '0;
      zero_reg  <= 1'b0;
      div0_reg  <= 1'b0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= '0;
      done      <= 1'b0;
      zero_flag <= 1'b0;
      div0_err  <= 1'b0;
    end else begin
      done     <= 1'b0;
      div0_err <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (req_valid && req_ready) begin
            op_reg    <= req_op;
            rd_reg    <= req_rd;
            rs1_reg   <= req_rs1;
            rs2_reg   <= req_rs2;
            state_reg <= READ;
          end
        end
        READ: begin
          alu_a     <= rf[rs1_reg];
          alu_b     <= rf[rs2_reg];
          alu_op    <= op_reg;
          state_reg <= EXEC;
        end
        EXEC: begin
          res_reg   <= alu_result;
          zero_reg  <= alu_zero;
          div0_reg  <= (alu_op == OP_DIV) && (alu_b == '0);
          state_reg <= WB;
        end
        WB: begin
          zero_flag <= zero_reg;
          done      <= 1'b1;
          div0_err  <= div0_reg;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural combinational ALU
// attached to the operand/result interface.
module tb_alu_issue_ctrl;

  localparam int W = 19;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid;
  logic         req_ready;
  logic [2:0]   req_op;
  logic [2:0]   req_rd;
  logic [2:0]   req_rs1;
  logic [2:0]   req_rs2;
  logic         ld_en;
  logic [2:0]   ld_idx;
  logic [W-1:0] ld_data;
  logic [2:0]   dbg_idx;
  logic [W-1:0] dbg_data;
  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic [2:0]   alu_op;
  logic [W-1:0] alu_result;
  logic         alu_zero;
  logic         done;
  logic         zero_flag;
  logic         div0_err;

  int checks = 0;
  int errors = 0;

  alu_issue_ctrl #(.WIDTH(W), .NREGS(8), .IDX_W(3)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2),
    .ld_en(ld_en), .ld_idx(ld_idx), .ld_data(ld_data),
    .dbg_idx(dbg_idx), .dbg_data(dbg_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .done(done), .zero_flag(zero_flag), .div0_err(div0_err)
  );

  always #5 clk = ~clk;

  // Behavioural ALU
  logic [2*W-1:0] prod;
  logic [W-1:0]   res;
  always_comb begin
    prod = (2*W)'(alu_a) * (2*W)'(alu_b);
    res  = '0;
    case (alu_op)
      3'b000: res = alu_a + alu_b;
      3'b001: res = alu_a - alu_b;
      3'b010: res = prod[W-1:0];
      3'b011: res = (alu_b == '0) ? '0 : alu_a / alu_b;
      3'b100: res = alu_a & alu_b;
      3'b101: res = alu_a | alu_b;
      3'b110: res = alu_a ^ alu_b;
      default: res = ~alu_a;
    endcase
  end
  assign alu_result = res;
  assign alu_zero   = (res == '0);

  task automatic peek(input logic [2:0] idx, output logic [W-1:0] v);
    dbg_idx = idx;
    #1;
    v = dbg_data;
  endtask

  task automatic do_load(input logic [2:0] idx, input logic [W-1:0] data);
    @(negedge clk);
    ld_en = 1'b1; ld_idx = idx; ld_data = data;
    @(negedge clk);
    ld_en = 1'b0;
    $display("load r%0d <= %h", idx, data);
  endtask

  // Issue one request and follow it to done (bounded); reports what was seen.
  task automatic run_op(input logic [2:0] op, input logic [2:0] rd,
                        input logic [2:0] rs1, input logic [2:0] rs2,
                        output int lat, output logic [W-1:0] a,
                        output logic [W-1:0] b, output logic [2:0] o,
                        output logic dz, output logic zf);
    lat = -1; a = '0; b = '0; o = '0; dz = 1'b0; zf = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_rd = rd; req_rs1 = rs1; req_rs2 = rs2;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (i == 1) req_valid = 1'b0;
      if (i == 2) begin a = alu_a; b = alu_b; o = alu_op; end
      if (done) begin
        lat = i; dz = div0_err; zf = zero_flag;
        break;
      end
    end
    $display("op %b rd r%0d rs1 r%0d rs2 r%0d a %h b %h lat %0d zf %b div0 %b",
             op, rd, rs1, rs2, a, b, lat, zf, dz);
  endtask

  task automatic test_reset;
    logic [W-1:0] v;
    rst = 1'b1; req_valid = 1'b0; req_op = '0; req_rd = '0; req_rs1 = '0;
    req_rs2 = '0; ld_en = 1'b0; ld_idx = '0; ld_data = '0; dbg_idx = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      peek(3'(i), v);
      checks++;
      if (v !== '0) begin
        errors++; $display("FAIL reset_reg r%0d: got %h expected 0", i, v);
      end
    end
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", req_ready); end
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++;
    if (zero_flag !== 1'b0) begin errors++; $display("FAIL reset_zf: got %b expected 0", zero_flag); end
    checks++;
    if ({alu_a, alu_b, alu_op} !== '0) begin
      errors++; $display("FAIL reset_alu: got %h %h %b expected 0", alu_a, alu_b, alu_op);
    end
  endtask

  task automatic test_add;
    int lat; logic [W-1:0] a, b, v; logic [2:0] o; logic dz, zf;
    do_load(3'd1, 19'd5);
    do_load(3'd2, 19'd3);
    run_op(OP_ADD, 3'd3, 3'd1, 3'd2, lat, a, b, o, dz, zf);
    checks++;
    if (a !== 19'd5 || b !== 19'd3 || o !== OP_ADD) begin
      errors++; $display("FAIL add_operands: got %h %h %b expected 00005 00003 000", a, b, o);
    end
    checks++;
    if (lat !== 4) begin errors++; $display("FAIL add_latency: got %0d expected 4", lat); end
    peek(3'd3, v);
    checks++;
    if (v !== 19'd8) begin errors++; $display("FAIL add_r3: got %h expected 00008", v); end
    checks++;
    if (zf !== 1'b0) begin errors++; $display("FAIL add_zf: got %b expected 0", zf); end
  endtask

  task automatic test_sub_div;
    int lat; logic [W-1:0] a, b, v; logic [2:0] o; logic dz, zf;
    do_load(3'd1, 19'd7);
    do_load(3'd2, 19'd7);
    do_load(3'd5, 19'd9);
    run_op(OP_SUB, 3'd4, 3'd1, 3'd2, lat, a, b, o, dz, zf);
    peek(3'd4, v);
    checks++;
    if (v !== '0) begin errors++; $display("FAIL sub_r4: got %h expected 0", v); end
    checks++;
    if (zf !== 1'b1 || dz !== 1'b0) begin
      errors++; $display("FAIL sub_flags: got zf %b div0 %b expected zf 1 div0 0", zf, dz);
    end
    run_op(OP_DIV, 3'd5, 3'd1, 3'd0, lat, a, b, o, dz, zf);
    peek(3'd5, v);
    checks++;
    if (v !== '0) begin errors++; $display("FAIL div_r5: got %h expected 0", v); end
    checks++;
    if (lat !== 4 || dz !== 1'b1) begin
      errors++; $display("FAIL div0_err: got lat %0d div0 %b expected lat 4 div0 1", lat, dz);
    end
    @(negedge clk);
    checks++;
    if (div0_err !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL div0_pulse: got div0 %b done %b expected 0 0", div0_err, done);
    end
  endtask

  task automatic test_r0_wrap;
    int lat; logic [W-1:0] a, b, v; logic [2:0] o; logic dz, zf;
    do_load(3'd1, 19'h7FFFF);
    do_load(3'd0, 19'h00123);
    peek(3'd0, v);
    checks++;
    if (v !== '0) begin errors++; $display("FAIL r0_load: got %h expected 0", v); end
    run_op(OP_ADD, 3'd0, 3'd1, 3'd1, lat, a, b, o, dz, zf);
    peek(3'd0, v);
    checks++;
    if (lat !== 4 || v !== '0) begin
      errors++; $display("FAIL r0_wb: got lat %0d r0 %h expected lat 4 r0 0", lat, v);
    end
    checks++;
    if (zf !== 1'b0) begin errors++; $display("FAIL r0_zf: got %b expected 0", zf); end
    run_op(OP_MUL, 3'd6, 3'd1, 3'd1, lat, a, b, o, dz, zf);
    peek(3'd6, v);
    checks++;
    if (v !== 19'h00001) begin errors++; $display("FAIL mul_r6: got %h expected 00001", v); end
  endtask

  task automatic test_back_to_back;
    logic [2:0] ops [3];
    logic [2:0] rds [3];
    int acc [3];
    int n, seen;
    logic [W-1:0] v;
    ops[0] = OP_ADD; ops[1] = OP_SUB; ops[2] = OP_AND;
    rds[0] = 3'd3;   rds[1] = 3'd4;   rds[2] = 3'd5;
    acc[0] = 0; acc[1] = 0; acc[2] = 0;
    n = 0;
    do_load(3'd1, 19'd6);
    do_load(3'd2, 19'd2);
    @(negedge clk);
    req_valid = 1'b1; req_op = ops[0]; req_rd = rds[0]; req_rs1 = 3'd1; req_rs2 = 3'd2;
    for (int c = 0; c < 40 && n < 3; c++) begin
      if (req_ready) begin acc[n] = c; n++; end
      @(negedge clk);
      if (n < 3) begin req_op = ops[n]; req_rd = rds[n]; end
      else req_valid = 1'b0;
    end
    req_valid = 1'b0;
    $display("b2b accepted %0d at cycles %0d %0d %0d", n, acc[0], acc[1], acc[2]);
    checks++;
    if (n !== 3 || acc[1] - acc[0] !== 4 || acc[2] - acc[1] !== 4) begin
      errors++; $display("FAIL b2b_spacing: got n %0d gaps %0d %0d expected 3 4 4",
                         n, acc[1] - acc[0], acc[2] - acc[1]);
    end
    seen = 0;
    for (int i = 0; i < 10 && seen == 0; i++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    checks++;
    if (seen !== 1) begin errors++; $display("FAIL b2b_done: got %0d expected 1", seen); end
    peek(3'd3, v);
    checks++;
    if (v !== 19'd8) begin errors++; $display("FAIL b2b_r3: got %h expected 00008", v); end
    peek(3'd4, v);
    checks++;
    if (v !== 19'd4) begin errors++; $display("FAIL b2b_r4: got %h expected 00004", v); end
    peek(3'd5, v);
    checks++;
    if (v !== 19'd2) begin errors++; $display("FAIL b2b_r5: got %h expected 00002", v); end

    // ld_en while busy must be ignored
    @(negedge clk);
    req_valid = 1'b1; req_op = OP_ADD; req_rd = 3'd7; req_rs1 = 3'd1; req_rs2 = 3'd2;
    @(negedge clk);
    req_valid = 1'b0; ld_en = 1'b1; ld_idx = 3'd2; ld_data = 19'h00055;
    @(negedge clk);
    ld_en = 1'b0;
    $display("load r2 <= 00055 during READ");
    peek(3'd2, v);
    checks++;
    if (v !== 19'd2) begin errors++; $display("FAIL busy_load: got %h expected 00002", v); end
    repeat (3) @(negedge clk);
    peek(3'd7, v);
    checks++;
    if (v !== 19'd8) begin errors++; $display("FAIL busy_r7: got %h expected 00008", v); end

    // load wins over a simultaneous request
    @(negedge clk);
    ld_en = 1'b1; ld_idx = 3'd6; ld_data = 19'h01234;
    req_valid = 1'b1; req_op = OP_ADD; req_rd = 3'd3; req_rs1 = 3'd1; req_rs2 = 3'd1;
    #1;
    checks++;
    if (req_ready !== 1'b0) begin errors++; $display("FAIL ld_prio_ready: got %b expected 0", req_ready); end
    @(negedge clk);
    ld_en = 1'b0; req_valid = 1'b0;
    $display("load r6 <= 01234 with req_valid");
    peek(3'd6, v);
    checks++;
    if (v !== 19'h01234) begin errors++; $display("FAIL ld_prio_r6: got %h expected 01234", v); end
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done) seen++;
    end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL ld_prio_noissue: got %0d done pulses expected 0", seen); end
  endtask

  task automatic test_reset_mid;
    int lat, seen; logic [W-1:0] a, b, v; logic [2:0] o; logic dz, zf;
    run_op(OP_SUB, 3'd4, 3'd1, 3'd1, lat, a, b, o, dz, zf);
    checks++;
    if (zf !== 1'b1) begin errors++; $display("FAIL pre_rst_zf: got %b expected 1", zf); end
    @(negedge clk);
    req_valid = 1'b1; req_op = OP_ADD; req_rd = 3'd3; req_rs1 = 3'd1; req_rs2 = 3'd2;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    $display("reset during EXEC");
    checks++;
    if ({alu_a, alu_b, alu_op, done, zero_flag, div0_err} !== '0) begin
      errors++; $display("FAIL mid_rst_outputs: got %h %h %b %b %b %b expected all 0",
                         alu_a, alu_b, alu_op, done, zero_flag, div0_err);
    end
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_ready: got %b expected 1", req_ready); end
    peek(3'd3, v);
    checks++;
    if (v !== '0) begin errors++; $display("FAIL mid_rst_r3: got %h expected 0", v); end
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done) seen++;
    end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL mid_rst_nodone: got %0d expected 0", seen); end
    do_load(3'd1, 19'd4);
    do_load(3'd2, 19'd9);
    run_op(OP_ADD, 3'd3, 3'd1, 3'd2, lat, a, b, o, dz, zf);
    peek(3'd3, v);
    checks++;
    if (lat !== 4 || v !== 19'd13) begin
      errors++; $display("FAIL post_rst_add: got lat %0d r3 %h expected lat 4 r3 0000d", lat, v);
    end
  endtask

  initial begin
    test_reset;
    test_add;
    test_sub_div;
    test_r0_wrap;
    test_back_to_back;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
